// File: rtl/pc_gen_pkg.sv
// Shared types for the PC generation stage; reused by decode and debug views.
package pc_gen_pkg;

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      RUN   = 3'd1,
      STALL = 3'd2,
      HALT  = 3'd3,
      FAULT = 3'd4
   } pc_state_t;

   localparam int unsigned PC_INSTR_BYTES = 4;

   // A redirect target is word-aligned only when its two low bits are zero.
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return (low_bits != 2'b00);
   endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// One-entry holding register for a redirect that arrives while the stage is stalled.
module pc_redirect_buffer #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_capture,
   input  logic                 i_overwrite,
   input  logic                 i_clear,
   input  logic [WORD_SIZE-1:0] i_target,
   output logic                 o_pending_valid,
   output logic [WORD_SIZE-1:0] o_pending_target
);

   logic                 r_valid;
   logic [WORD_SIZE-1:0] r_target;

   // Clear dominates; overwrite replaces the target of an already-held redirect.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid  <= 1'b0;
         r_target <= '0;
      end else if (i_clear) begin
         r_valid  <= 1'b0;
      end else if (i_capture) begin
         r_valid  <= 1'b1;
         r_target <= i_target;
      end else if (i_overwrite) begin
         r_target <= i_target;
      end
   end

   assign o_pending_valid  = r_valid;
   assign o_pending_target = r_target;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generation upstream of fetch: sequential step, redirect, stall, halt.
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                   WORD_SIZE    = 32,
   parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
   parameter int                   INSTR_BYTES  = PC_INSTR_BYTES
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [WORD_SIZE-1:0] redirect_target,
   input  logic                 halt_req,
   output logic [WORD_SIZE-1:0] pc,
   output logic                 pc_valid,
   output logic [2:0]           state,
   output logic                 fault
);

   pc_state_t            r_state;
   logic [WORD_SIZE-1:0] r_pc;

   pc_state_t            w_next_state;
   logic [WORD_SIZE-1:0] w_next_pc;
   logic [WORD_SIZE-1:0] w_pc_inc;
   logic                 w_bad_redirect;
   logic                 w_buf_capture;
   logic                 w_buf_overwrite;
   logic                 w_buf_clear;
   logic                 w_pend_valid;
   logic [WORD_SIZE-1:0] w_pend_target;

   assign w_pc_inc = r_pc + WORD_SIZE'(INSTR_BYTES);

`ifdef PC_ALIGN_CHECK_EN
   assign w_bad_redirect = redirect_valid && is_misaligned(redirect_target[1:0]);
`else
   assign w_bad_redirect = 1'b0;
`endif

   pc_redirect_buffer #(
      .WORD_SIZE(WORD_SIZE)
   ) u_redirect_buffer (
      .i_clk            (clock),
      .i_rst            (reset),
      .i_capture        (w_buf_capture),
      .i_overwrite      (w_buf_overwrite),
      .i_clear          (w_buf_clear),
      .i_target         (redirect_target),
      .o_pending_valid  (w_pend_valid),
      .o_pending_target (w_pend_target)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= BOOT;
         r_pc    <= RESET_VECTOR;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
      end
   end

   // enable=0 leaves every default in place, so nothing moves and redirects are dropped.
   always_comb begin
      w_next_state    = r_state;
      w_next_pc       = r_pc;
      w_buf_capture   = 1'b0;
      w_buf_overwrite = 1'b0;
      w_buf_clear     = 1'b0;
      if (enable) begin
         case (r_state)
            BOOT: begin
               w_next_state = RUN;
            end
            RUN: begin
               if (w_bad_redirect) begin
                  w_next_state = FAULT;
               end else if (redirect_valid) begin
                  w_next_pc = redirect_target;
                  if (stall) w_next_state = STALL;
               end else if (halt_req) begin
                  w_next_state = HALT;
               end else if (stall) begin
                  w_next_state = STALL;
               end else begin
                  w_next_pc = w_pc_inc;
               end
            end
            STALL: begin
               if (w_bad_redirect) begin
                  w_next_state = FAULT;
                  w_buf_clear  = 1'b1;
               end else if (halt_req) begin
                  w_next_state = HALT;
                  w_buf_clear  = 1'b1;
               end else if (stall) begin
                  w_buf_capture   = redirect_valid && !w_pend_valid;
                  w_buf_overwrite = redirect_valid && w_pend_valid;
               end else begin
                  // Release: a same-cycle redirect beats the buffered one.
                  if (redirect_valid)    w_next_pc = redirect_target;
                  else if (w_pend_valid) w_next_pc = w_pend_target;
                  else                   w_next_pc = w_pc_inc;
                  w_buf_clear  = 1'b1;
                  w_next_state = RUN;
               end
            end
            HALT: begin
               if (w_bad_redirect) begin
                  w_next_state = FAULT;
               end else if (redirect_valid) begin
                  w_next_pc    = redirect_target;
                  w_next_state = RUN;
               end
            end
            FAULT: begin
               w_next_state = FAULT;
            end
            default: begin
               w_next_state = BOOT;
            end
         endcase
      end
   end

   assign pc       = r_pc;
   assign pc_valid = enable && !stall && (r_state == RUN);
   assign state    = r_state;
   assign fault    = (r_state == FAULT);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed table, corner sequences, randomized run vs reference model.
module tb_pc_gen;
   import pc_gen_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clock;
   logic        reset;
   logic        enable;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt_req;
   logic [31:0] pc;
   logic        pc_valid;
   logic [2:0]  state;
   logic        fault;

   int n_vec;
   int n_mis;

   pc_gen #(
      .WORD_SIZE   (32),
      .RESET_VECTOR(RV),
      .INSTR_BYTES (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .halt_req       (halt_req),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .state          (state),
      .fault          (fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached (pc=%h, required finish)", pc);
      $fatal(1);
   end

   // Reference model: mode, PC, and a queue of redirects seen while stalled.
   pc_state_t   m_state;
   logic [31:0] m_pc;
   logic [31:0] pend_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = BOOT;
      m_pc    = RV;
      pend_q.delete();
   endtask

   task automatic model_update(input logic en, input logic st, input logic rv,
                               input logic [31:0] rt, input logic hr);
      logic bad;
      if (!en) return;
      bad = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      bad = rv && ((rt % 4) != 0);
`endif
      case (m_state)
         BOOT: m_state = RUN;
         RUN: begin
            if (bad) m_state = FAULT;
            else if (rv) begin
               m_pc = rt;
               if (st) m_state = STALL;
            end else if (hr) m_state = HALT;
            else if (st) m_state = STALL;
            else m_pc = m_pc + 4;
         end
         STALL: begin
            if (bad) begin
               m_state = FAULT;
               pend_q.delete();
            end else if (hr) begin
               m_state = HALT;
               pend_q.delete();
            end else if (st) begin
               if (rv) pend_q.push_back(rt);
            end else begin
               if (rv) m_pc = rt;
               else if (pend_q.size() > 0) m_pc = pend_q[$];
               else m_pc = m_pc + 4;
               pend_q.delete();
               m_state = RUN;
            end
         end
         HALT: begin
            if (bad) m_state = FAULT;
            else if (rv) begin
               m_pc    = rt;
               m_state = RUN;
            end
         end
         default: ;
      endcase
   endtask

   // Drive at negedge, compare the pre-edge view, then advance the model for the coming edge.
   task automatic step(input logic en, input logic st, input logic rv,
                       input logic [31:0] rt, input logic hr);
      @(negedge clock);
      enable          = en;
      stall           = st;
      redirect_valid  = rv;
      redirect_target = rt;
      halt_req        = hr;
      #1;
      chk("pc", pc, m_pc);
      chk("pc_valid", 32'(pc_valid), 32'(m_state == RUN && en && !st));
      chk("state", 32'(state), 32'(m_state));
      chk("fault", 32'(fault), 32'(m_state == FAULT));
      model_update(en, st, rv, rt, hr);
   endtask

   task automatic do_reset();
      enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_pc", pc, RV);
      chk("rst_state", 32'(state), 32'(BOOT));
      chk("rst_pc_valid", 32'(pc_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        en;
      logic        st;
      logic        rv;
      logic [31:0] rt;
      logic        hr;
      logic [31:0] exp_pc;
      logic        exp_valid;
      pc_state_t   exp_state;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic en, input logic st, input logic rv, input logic [31:0] rt,
                      input logic hr, input logic [31:0] p, input logic v, input pc_state_t s);
      vec_t e;
      e.en = en; e.st = st; e.rv = rv; e.rt = rt; e.hr = hr;
      e.exp_pc = p; e.exp_valid = v; e.exp_state = s;
      tbl.push_back(e);
   endtask

   initial begin
      logic [31:0] r;
      n_vec = 0;
      n_mis = 0;
      reset = 1'b0;
      enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      redirect_target = '0; halt_req = 1'b0;

      //  en st rv target        hr  pc            valid state
      add(1, 0, 0, 32'h0,        0, 32'h100,       0, BOOT);
      add(1, 0, 0, 32'h0,        0, 32'h100,       1, RUN);
      add(1, 0, 0, 32'h0,        0, 32'h104,       1, RUN);
      add(1, 0, 0, 32'h0,        0, 32'h108,       1, RUN);
      add(1, 0, 1, 32'h200,      0, 32'h10C,       1, RUN);
      add(1, 0, 1, 32'h400,      0, 32'h200,       1, RUN);
      add(1, 0, 0, 32'h0,        0, 32'h400,       1, RUN);
      add(1, 0, 1, 32'h300,      0, 32'h404,       1, RUN);
      add(1, 1, 0, 32'h0,        0, 32'h300,       0, RUN);
      add(1, 1, 1, 32'h500,      0, 32'h300,       0, STALL);
      add(1, 1, 1, 32'h600,      0, 32'h300,       0, STALL);
      add(1, 0, 0, 32'h0,        0, 32'h300,       0, STALL);
      add(1, 0, 0, 32'h0,        0, 32'h600,       1, RUN);
      add(1, 0, 1, 32'hFFFFFFFC, 0, 32'h604,       1, RUN);
      add(1, 0, 0, 32'h0,        0, 32'hFFFFFFFC,  1, RUN);
      add(1, 0, 1, 32'h120,      0, 32'h0,         1, RUN);
      add(1, 0, 0, 32'h0,        1, 32'h120,       1, RUN);
      add(1, 0, 0, 32'h0,        0, 32'h120,       0, HALT);
      add(1, 0, 0, 32'h0,        1, 32'h120,       0, HALT);
      add(1, 0, 1, 32'h80,       0, 32'h120,       0, HALT);
      add(1, 0, 0, 32'h0,        0, 32'h80,        1, RUN);
      add(0, 0, 1, 32'h999C,     0, 32'h84,        0, RUN);
      add(1, 0, 0, 32'h0,        0, 32'h84,        1, RUN);
      add(1, 1, 1, 32'h700,      0, 32'h88,        0, RUN);
      add(1, 1, 0, 32'h0,        0, 32'h700,       0, STALL);
      add(1, 0, 0, 32'h0,        0, 32'h700,       0, STALL);
      add(1, 0, 0, 32'h0,        0, 32'h704,       1, RUN);
      add(1, 1, 0, 32'h0,        0, 32'h708,       0, RUN);
      add(1, 1, 1, 32'hA00,      0, 32'h708,       0, STALL);
      add(1, 1, 0, 32'h0,        1, 32'h708,       0, STALL);
      add(1, 0, 1, 32'hB00,      0, 32'h708,       0, HALT);
      add(1, 1, 0, 32'h0,        0, 32'hB00,       0, RUN);
      add(1, 0, 1, 32'hC00,      0, 32'hB00,       0, STALL);
      add(1, 0, 0, 32'h0,        0, 32'hC00,       1, RUN);

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].en, tbl[i].st, tbl[i].rv, tbl[i].rt, tbl[i].hr);
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
         chk($sformatf("tbl%0d_valid", i), 32'(pc_valid), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
      end

      // Async reset while a redirect is buffered must drop it.
      step(1, 1, 0, 32'h0, 0);
      step(1, 1, 1, 32'hD00, 0);
      do_reset();
      step(1, 0, 0, 32'h0, 0);
      step(1, 1, 0, 32'h0, 0);
      step(1, 0, 0, 32'h0, 0);
      step(1, 0, 0, 32'h0, 0);
      chk("rst_clears_pending", pc, 32'h104);

      // Misaligned redirect.
      do_reset();
      step(1, 0, 0, 32'h0, 0);
      step(1, 0, 1, 32'h402, 0);
      step(1, 0, 0, 32'h0, 0);
`ifdef PC_ALIGN_CHECK_EN
      chk("align_fault", 32'(fault), 32'd1);
      chk("align_state", 32'(state), 32'(FAULT));
      chk("align_pc_hold", pc, 32'h100);
      chk("align_pc_valid", 32'(pc_valid), 32'd0);
`else
      chk("noalign_fault", 32'(fault), 32'd0);
      chk("noalign_pc", pc, 32'h402);
`endif
      do_reset();
      chk("fault_cleared", 32'(fault), 32'd0);

      // Randomized run against the reference model.
      for (int c = 0; c < 2000; c++) begin
         logic en, st, rv, hr;
         logic [31:0] rt;
         if ($urandom_range(0, 249) == 0) do_reset();
         en = ($urandom_range(0, 9) != 0);
         st = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 5) == 0);
         hr = ($urandom_range(0, 15) == 0);
         r  = $urandom;
         case ($urandom_range(0, 7))
            0:       rt = 32'hFFFF_FFF0 + {28'd0, r[3:2], 2'b00};
            1:       rt = r;
            default: rt = {r[31:2], 2'b00};
         endcase
         step(en, st, rv, rt, hr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
